onehot_decoder_seq: RTL and testbench
=====================================

Name: onehot_decoder_seq

Overview:
- Sequenced one-hot decoder: the inverse of the team's 8-input one-hot encoder.
- Accepts a 4-bit binary code over a valid/ready handshake.
- Drives the matching one-hot line of an 8-bit registered output for a fixed number of cycles, then a fixed idle gap.
- Used to strobe one of N select/enable lines from a compact code; codes outside the one-hot range are rejected and counted.

Parameters:
- N_OUT, 8, number of one-hot output lines; legal codes 0..N_OUT-1.
- CODE_W, 4, input code width; must satisfy 2**CODE_W >= N_OUT.
- HOLD, 4, cycles the one-hot output stays asserted; legal range 1..255.
- GAP, 1, forced idle cycles after HOLD before the next accept; legal range 0..255.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  code present on in_code.
- in_ready  out  1  block can accept a code this cycle.
- in_code  in  CODE_W  binary code to decode.
- out  out  N_OUT  registered one-hot output (all-zero when idle).
- out_valid  out  1  high exactly while out is non-zero.
- busy  out  1  high in the DRIVE and GAP states.
- err  out  1  one-cycle pulse on acceptance of an illegal code.
- err_cnt  out  8  saturating count of illegal codes accepted.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: state=IDLE, out=0, out_valid=0, busy=0, err=0, err_cnt=0, cnt=0, in_ready=0.
- in_ready is high one cycle after rst_n deasserts. in_ready is combinational: in_ready = (state==IDLE) && reset released.
- Accept condition: in_valid && in_ready sampled at a rising edge. in_code is sampled only at accept.
- IDLE with a legal code accepted (in_code < N_OUT):
  - Next state DRIVE.
  - out <= 1<<in_code and out_valid <= 1, both visible after the accept edge (latency 1).
  - cnt <= HOLD-1.
- DRIVE:
  - cnt != 0: decrement.
  - cnt == 0: out <= 0, out_valid <= 0. Go to GAP with cnt <= GAP-1 if GAP > 0, else go to IDLE.
  - out is therefore high for exactly HOLD cycles.
- GAP: out=0, in_ready=0. When cnt == 0, go to IDLE; otherwise decrement.
- Back-to-back: with GAP=0, a new code is accepted on the first IDLE cycle, so there is one idle cycle between strobes. With GAP=g there are g+1 idle cycles.
- IDLE with an illegal code accepted (in_code >= N_OUT):
  - State stays IDLE; out stays 0.
  - err=1 for one cycle after the edge.
  - err_cnt increments, saturating at 255 (no wrap).
  - in_ready stays high, so an illegal code costs no throughput.
- in_valid while busy is ignored. The producer holds in_valid and in_code until in_ready.
- out is always zero or exactly one-hot, never multi-hot. The bench asserts $onehot0(out) and out_valid == |out.
- Reset asserted mid-DRIVE or mid-GAP: out clears immediately (asynchronously), err_cnt clears, the pending strobe is abandoned and not replayed.
- X on in_code when not accepted: no effect.

Decomposition:
- Package onehot_dec_pkg holds:
  - state enum state_t {IDLE, DRIVE, GAP}, 2 bits.
  - localparam ERR_CNT_MAX=8'hFF.
  - function for the legality check (code < N_OUT).
- Sub-module hold_counter: 8-bit load/decrement down-counter with a zero flag.
- The FSM and decode logic stay in the top module.

Test Plan:
1. Reset release, then in_code=4'd0..7 each with in_valid=1 held until accepted (HOLD=4, GAP=1) -> out = 8'h01, 02, 04, …, 80 in turn; each high 4 cycles; 2 zero cycles between strobes; in_ready low during DRIVE/GAP.
2. in_code=4'd9 in IDLE -> err pulse of 1 cycle; out stays 8'h00; err_cnt=1; in_ready stays 1. Then in_code=4'd3 the next cycle -> out=8'h08 after one edge.
3. 300 consecutive illegal codes (4'd8..4'd15) -> err_cnt saturates at 8'hFF and does not wrap.
4. Accept in_code=4'd5, pull rst_n low 2 cycles into DRIVE, between clock edges -> out goes 8'h00 immediately without waiting for an edge; after release, state IDLE, no residual strobe, err_cnt=0.
5. GAP=0, HOLD=1, continuous in_valid with codes 2,6 -> out=8'h04 for 1 cycle, 8'h00 for 1 cycle, 8'h40 for 1 cycle.
6. in_valid pulsed with code 7 while in DRIVE for code 1 -> request ignored unless held; out never multi-hot; the 8'h80 strobe appears only once in_valid is held into IDLE.

Source files
------------

// File: rtl/onehot_dec_pkg.sv
// Shared types, constants and helpers for the sequenced one-hot decoder.
package onehot_dec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    // A code is legal when it selects one of the existing output lines.
    function automatic logic code_is_legal(input int unsigned code, input int unsigned n_out);
        return (code < n_out);
    endfunction

endpackage

// File: rtl/onehot_decoder_seq_hold_counter.sv
// 8-bit down-counter: load has priority, decrement stops at zero.
module hold_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [7:0] cnt_r;

    // Load a new count or step the current one down towards zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 8'd0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != 8'd0)) begin
            cnt_r <= cnt_r - 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == 8'd0);

endmodule

// File: rtl/onehot_decoder_seq.sv
// Sequenced one-hot decoder: accepts a binary code, strobes the matching
// output line for HOLD cycles, then enforces GAP idle cycles.
import onehot_dec_pkg::*;

module onehot_decoder_seq #(
    parameter int N_OUT  = 8,
    parameter int CODE_W = 4,
    parameter int HOLD   = 4,
    parameter int GAP    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic [N_OUT-1:0]  out,
    output logic              out_valid,
    output logic              busy,
    output logic              err,
    output logic [7:0]        err_cnt
);

    localparam logic [7:0]       HOLD_LD = 8'(HOLD - 1);
    localparam logic             GAP_EN  = (GAP > 0) ? 1'b1 : 1'b0;
    localparam logic [7:0]       GAP_LD  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
    localparam logic [N_OUT-1:0] ONE     = {{(N_OUT-1){1'b0}}, 1'b1};

    state_t             state_r;
    logic [N_OUT-1:0]   out_r;
    logic               out_valid_r;
    logic               err_r;
    logic [7:0]         err_cnt_r;
    logic               rst_done_r;

    logic               accept_s;
    logic               legal_s;
    logic               cnt_load_s;
    logic [7:0]         cnt_load_val_s;
    logic               cnt_dec_s;
    logic               cnt_zero_s;

    assign in_ready  = (state_r == IDLE) && rst_done_r;
    assign accept_s  = in_valid && in_ready;
    assign legal_s   = code_is_legal(32'(in_code), 32'(N_OUT));

    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign busy      = (state_r != IDLE);
    assign err       = err_r;
    assign err_cnt   = err_cnt_r;

    // Counter control: load HOLD on a legal accept, GAP at end of drive, else count down.
    always_comb begin
        cnt_load_s     = 1'b0;
        cnt_load_val_s = 8'd0;
        cnt_dec_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s && legal_s) begin
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = HOLD_LD;
                end else begin
                    cnt_load_s     = 1'b0;
                end
            end
            DRIVE: begin
                if (cnt_zero_s) begin
                    if (GAP_EN) begin
                        cnt_load_s     = 1'b1;
                        cnt_load_val_s = GAP_LD;
                    end else begin
                        cnt_load_s     = 1'b0;
                    end
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            onehot_dec_pkg::GAP: begin
                if (!cnt_zero_s) begin
                    cnt_dec_s = 1'b1;
                end else begin
                    cnt_dec_s = 1'b0;
                end
            end
            default: begin
                cnt_load_s = 1'b0;
            end
        endcase
    end

    hold_counter u_hold_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load_s),
        .load_val (cnt_load_val_s),
        .dec      (cnt_dec_s),
        .zero     (cnt_zero_s)
    );

    // Main FSM with registered strobe, error pulse and saturating error count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            out_r       <= '0;
            out_valid_r <= 1'b0;
            err_r       <= 1'b0;
            err_cnt_r   <= 8'd0;
            rst_done_r  <= 1'b0;
        end else begin
            rst_done_r <= 1'b1;
            err_r      <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (legal_s) begin
                            state_r     <= DRIVE;
                            out_r       <= ONE << in_code;
                            out_valid_r <= 1'b1;
                        end else begin
                            // Illegal codes are consumed in place: no strobe, no throughput loss.
                            err_r <= 1'b1;
                            if (err_cnt_r != ERR_CNT_MAX) begin
                                err_cnt_r <= err_cnt_r + 8'd1;
                            end
                        end
                    end
                end
                DRIVE: begin
                    if (cnt_zero_s) begin
                        out_r       <= '0;
                        out_valid_r <= 1'b0;
                        state_r     <= GAP_EN ? onehot_dec_pkg::GAP : IDLE;
                    end
                end
                onehot_dec_pkg::GAP: begin
                    if (cnt_zero_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_r       <= '0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed bench for onehot_decoder_seq: instance a uses HOLD=4/GAP=1,
// instance b uses HOLD=1/GAP=0 for the back-to-back case.
module tb_onehot_decoder_seq;

    logic       clk;
    logic       rst_n;

    logic       a_valid, a_ready, a_out_valid, a_busy, a_err;
    logic [3:0] a_code;
    logic [7:0] a_out, a_err_cnt;

    logic       b_valid, b_ready, b_out_valid, b_busy, b_err;
    logic [3:0] b_code;
    logic [7:0] b_out, b_err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    onehot_decoder_seq #(.N_OUT(8), .CODE_W(4), .HOLD(4), .GAP(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready),
        .in_code(a_code), .out(a_out), .out_valid(a_out_valid), .busy(a_busy),
        .err(a_err), .err_cnt(a_err_cnt)
    );

    onehot_decoder_seq #(.N_OUT(8), .CODE_W(4), .HOLD(1), .GAP(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
        .in_code(b_code), .out(b_out), .out_valid(b_out_valid), .busy(b_busy),
        .err(b_err), .err_cnt(b_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    // Output shape is checked every cycle: zero or one-hot, out_valid tracks |out.
    always @(negedge clk) begin
        n_cmp++;
        if (!$onehot0(a_out) || (a_out_valid !== (|a_out))) begin
            n_bad++;
            $display("FAIL a_shape: out=%h out_valid=%b, need one-hot/zero with out_valid=|out", a_out, a_out_valid);
        end
        n_cmp++;
        if (!$onehot0(b_out) || (b_out_valid !== (|b_out))) begin
            n_bad++;
            $display("FAIL b_shape: out=%h out_valid=%b, need one-hot/zero with out_valid=|out", b_out, b_out_valid);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; a_valid = 1'b0; a_code = 4'd0; b_valid = 1'b0; b_code = 4'd0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (a_out !== 8'h00) begin n_bad++; $display("FAIL rst_out: got %h expected %h", a_out, 8'h00); end
        n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b expected 0", a_out_valid); end
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", a_busy); end
        n_cmp++; if (a_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b expected 0", a_err); end
        n_cmp++; if (a_err_cnt !== 8'h00) begin n_bad++; $display("FAIL rst_err_cnt: got %h expected 00", a_err_cnt); end
        n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b expected 0", a_ready); end
        step();
        step();
        rst_n = 1'b1;
        n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL rel_ready_early: got %b expected 0", a_ready); end
        step();
        n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL rel_ready: got %b expected 1", a_ready); end
        n_cmp++; if (b_ready !== 1'b1) begin n_bad++; $display("FAIL rel_ready_b: got %b expected 1", b_ready); end
    endtask

    task automatic test_sequence();
        logic [7:0] exp_tbl [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        logic got;
        for (int c = 0; c < 8; c++) begin
            a_valid = 1'b1;
            a_code  = 4'(c);
            got = 1'b0;
            for (int w = 0; (w < 20) && !got; w++) begin
                if (a_ready) got = 1'b1;
                step();
            end
            n_cmp++; if (!got) begin n_bad++; $display("FAIL seq_accept: code %0d got no in_ready expected accept", c); end
            a_valid = 1'b0;
            a_code  = 4'bxxxx;
            for (int k = 0; k < 4; k++) begin
                n_cmp++; if (a_out !== exp_tbl[c]) begin n_bad++; $display("FAIL seq_out: code %0d cycle %0d got %h expected %h", c, k, a_out, exp_tbl[c]); end
                n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL seq_ready_drive: got %b expected 0", a_ready); end
                n_cmp++; if (a_busy !== 1'b1) begin n_bad++; $display("FAIL seq_busy_drive: got %b expected 1", a_busy); end
                step();
            end
            n_cmp++; if (a_out !== 8'h00) begin n_bad++; $display("FAIL seq_gap_out: got %h expected 00", a_out); end
            n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL seq_gap_ready: got %b expected 0", a_ready); end
            n_cmp++; if (a_busy !== 1'b1) begin n_bad++; $display("FAIL seq_gap_busy: got %b expected 1", a_busy); end
            step();
            n_cmp++; if (a_out !== 8'h00) begin n_bad++; $display("FAIL seq_idle_out: got %h expected 00", a_out); end
            n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL seq_idle_ready: got %b expected 1", a_ready); end
            n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL seq_idle_busy: got %b expected 0", a_busy); end
        end
    endtask

    task automatic test_illegal();
        a_valid = 1'b1;
        a_code  = 4'd9;
        step();
        n_cmp++; if (a_err !== 1'b1) begin n_bad++; $display("FAIL ill_err: got %b expected 1", a_err); end
        n_cmp++; if (a_out !== 8'h00) begin n_bad++; $display("FAIL ill_out: got %h expected 00", a_out); end
        n_cmp++; if (a_err_cnt !== 8'h01) begin n_bad++; $display("FAIL ill_err_cnt: got %h expected 01", a_err_cnt); end
        n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL ill_ready: got %b expected 1", a_ready); end
        a_code = 4'd3;
        step();
        a_valid = 1'b0;
        n_cmp++; if (a_err !== 1'b0) begin n_bad++; $display("FAIL ill_err_pulse: got %b expected 0", a_err); end
        n_cmp++; if (a_out !== 8'h08) begin n_bad++; $display("FAIL ill_then_legal_out: got %h expected 08", a_out); end
        for (int k = 0; k < 5; k++) step();
        n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL ill_drain_ready: got %b expected 1", a_ready); end
    endtask

    task automatic test_saturate();
        int exp_cnt = 1;
        a_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a_code = 4'(8 + (i % 8));
            step();
            if (exp_cnt < 255) exp_cnt++;
            n_cmp++; if (a_err_cnt !== 8'(exp_cnt)) begin n_bad++; $display("FAIL sat_cnt: iter %0d got %h expected %h", i, a_err_cnt, 8'(exp_cnt)); end
            n_cmp++; if ((a_err !== 1'b1) || (a_ready !== 1'b1)) begin n_bad++; $display("FAIL sat_err_ready: iter %0d got err=%b ready=%b expected 1/1", i, a_err, a_ready); end
        end
        a_valid = 1'b0;
        step();
        n_cmp++; if (a_err !== 1'b0) begin n_bad++; $display("FAIL sat_err_idle: got %b expected 0", a_err); end
        n_cmp++; if (a_err_cnt !== 8'hFF) begin n_bad++; $display("FAIL sat_hold: got %h expected FF", a_err_cnt); end
    endtask

    task automatic test_reset_mid_drive();
        a_valid = 1'b1;
        a_code  = 4'd5;
        step();
        a_valid = 1'b0;
        n_cmp++; if (a_out !== 8'h20) begin n_bad++; $display("FAIL rmd_out: got %h expected 20", a_out); end
        step();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (a_out !== 8'h00) begin n_bad++; $display("FAIL rmd_async_out: got %h expected 00", a_out); end
        n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL rmd_async_valid: got %b expected 0", a_out_valid); end
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL rmd_async_busy: got %b expected 0", a_busy); end
        n_cmp++; if (a_err_cnt !== 8'h00) begin n_bad++; $display("FAIL rmd_err_cnt: got %h expected 00", a_err_cnt); end
        n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL rmd_ready: got %b expected 0", a_ready); end
        step();
        step();
        rst_n = 1'b1;
        step();
        n_cmp++; if ((a_ready !== 1'b1) || (a_busy !== 1'b0)) begin n_bad++; $display("FAIL rmd_idle: got ready=%b busy=%b expected 1/0", a_ready, a_busy); end
        for (int k = 0; k < 6; k++) begin
            n_cmp++; if (a_out !== 8'h00) begin n_bad++; $display("FAIL rmd_no_replay: cycle %0d got %h expected 00", k, a_out); end
            n_cmp++; if (a_err_cnt !== 8'h00) begin n_bad++; $display("FAIL rmd_cnt_zero: got %h expected 00", a_err_cnt); end
            step();
        end
    endtask

    task automatic test_back_to_back();
        b_valid = 1'b1;
        b_code  = 4'd2;
        step();
        n_cmp++; if (b_out !== 8'h04) begin n_bad++; $display("FAIL b2b_first: got %h expected 04", b_out); end
        n_cmp++; if (b_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_drive: got %b expected 0", b_ready); end
        b_code = 4'd6;
        step();
        n_cmp++; if (b_out !== 8'h00) begin n_bad++; $display("FAIL b2b_idle: got %h expected 00", b_out); end
        n_cmp++; if (b_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_idle: got %b expected 1", b_ready); end
        step();
        b_valid = 1'b0;
        n_cmp++; if (b_out !== 8'h40) begin n_bad++; $display("FAIL b2b_second: got %h expected 40", b_out); end
        step();
        n_cmp++; if (b_out !== 8'h00) begin n_bad++; $display("FAIL b2b_end: got %h expected 00", b_out); end
        step();
        n_cmp++; if ((b_out !== 8'h00) || (b_busy !== 1'b0)) begin n_bad++; $display("FAIL b2b_quiet: got out=%h busy=%b expected 00/0", b_out, b_busy); end
    endtask

    task automatic test_ignore_while_busy();
        logic got;
        a_valid = 1'b1;
        a_code  = 4'd1;
        step();
        n_cmp++; if (a_out !== 8'h02) begin n_bad++; $display("FAIL ign_first: got %h expected 02", a_out); end
        a_code = 4'd7;
        step();
        a_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            n_cmp++; if (a_out !== 8'h02) begin n_bad++; $display("FAIL ign_hold: cycle %0d got %h expected 02", k, a_out); end
            step();
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (a_out !== 8'h00) begin n_bad++; $display("FAIL ign_dropped: cycle %0d got %h expected 00", k, a_out); end
            step();
        end
        a_valid = 1'b1;
        got = 1'b0;
        for (int w = 0; (w < 20) && !got; w++) begin
            if (a_ready) got = 1'b1;
            step();
        end
        a_valid = 1'b0;
        n_cmp++; if (!got) begin n_bad++; $display("FAIL ign_accept: got no in_ready expected accept"); end
        n_cmp++; if (a_out !== 8'h80) begin n_bad++; $display("FAIL ign_held: got %h expected 80", a_out); end
        for (int k = 0; k < 6; k++) step();
        n_cmp++; if ((a_out !== 8'h00) || (a_ready !== 1'b1)) begin n_bad++; $display("FAIL ign_drain: got out=%h ready=%b expected 00/1", a_out, a_ready); end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_illegal();
        test_saturate();
        test_reset_mid_drive();
        test_back_to_back();
        test_ignore_while_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
